output_port_arbiter: RTL and testbench
======================================

# output_port_arbiter

Per-output-port wormhole arbiter for the 5-port mesh router. It collects the one-bit port requests that each input port's LBDR routing unit raises for this output, and grants the output to one input at a time. The grant is held from the HEADER flit until the TAIL flit of that packet has been transferred. Transfers are gated by a credit counter that tracks free slots in the downstream input FIFO. One instance sits beside the crossbar for each of the N, E, W, S and L outputs.

## Interface
Parameters:
- CREDITS, 4, depth of the downstream input FIFO; reset value of the credit counter
- CNT_W, 3, width of the credit counter; must hold CREDITS

Ports (input index order everywhere: 0=N, 1=E, 2=W, 3=S, 4=L):
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req  in  5  per-input request for this output (that input's LBDR port bit)
- valid  in  5  per-input FIFO non-empty
- tail  in  5  per-input head flit is TAIL (flit_id == `TAIL)
- credit_in  in  1  downstream FIFO freed one slot this cycle
- grant  out  5  one-hot registered grant, crossbar select; 0 when idle
- xfer  out  1  flit moves this cycle; pops the granted FIFO and drives downstream write
- credit_cnt  out  CNT_W  current downstream free-slot count
- busy  out  1  arbiter locked to a packet

## Operation
- States: IDLE, LOCKED. Reset state is IDLE.
- Reset values: grant=0, busy=0, credit_cnt=CREDITS, priority pointer ptr=0. xfer=0 because grant=0.
- Eligible inputs: cand = req & valid.
- IDLE, cand≠0: the winner is the first set bit of cand, searched circularly from ptr upward (4 wraps to 0).
  - Next cycle: grant=onehot(winner), state LOCKED.
- IDLE, cand=0: stay in IDLE, grant=0.
- LOCKED: xfer = |(grant & valid) & (credit_cnt≠0). This is combinational from registered state and the current inputs.
  - req is ignored while LOCKED. Only valid, tail and credits matter for the held input.
  - valid[g]=0 or credit_cnt=0: stall. grant is held and no xfer occurs.
  - xfer & tail[g]: next cycle state IDLE, grant=0, ptr=(g+1) mod 5.
- Credit counter:
  - xfer only: decrement.
  - credit_in only: increment, saturating at CREDITS; an extra credit at full is dropped.
  - Both in the same cycle: unchanged.
  - Never decrements below 0, because xfer requires credit_cnt≠0.
- rst asserted mid-packet: all state returns to reset values on the next edge. The partially sent packet is abandoned. Upstream and downstream flushing is handled elsewhere.
- Requests from an input toward its own direction are not filtered here. LBDR never raises them.

## Timing
- Request-to-grant latency: cand seen in an IDLE cycle t gives grant in cycle t+1. The first xfer is possible in t+1.
- Throughput: 1 flit/cycle while LOCKED with valid and credits available.
- Packet turnaround: TAIL xfer in cycle t, IDLE in t+1, next grant at t+2. One bubble cycle per packet is accepted.
- The credit_cnt used to qualify xfer is the registered value. A credit_in arriving in the same cycle does not enable that cycle's xfer.
- Outputs grant, busy and credit_cnt are registered. xfer is combinational.

## Configuration
- OUT_ARB_RR_EN defined: round-robin arbitration as above, with ptr updated on every TAIL transfer.
- OUT_ARB_RR_EN undefined: fixed priority with index 0 (N) highest and 4 (L) lowest. ptr is held at 0 and is not updated. All other behaviour is identical.

## Test plan
- Reset, then req=5'b10000, valid=5'b10000 in IDLE → grant=5'b10000 one cycle later. xfer=1 every cycle of a 3-flit packet, tail on the 3rd. credit_cnt goes 4→1. grant=0 the cycle after the tail.
- Four 1-flit-tail packets from inputs N and E requested continuously → with RR_EN, grants alternate N,E,N,E with one idle cycle between. Without RR_EN, N wins every time.
- Credit exhaustion: CREDITS=4, a 6-flit packet, no credit_in → xfer stops after 4 flits with credit_cnt=0 and grant held. A credit_in pulse lets exactly one more flit through on the following cycle.
- Simultaneous xfer and credit_in with credit_cnt=2 → credit_cnt stays 2. credit_in at credit_cnt=4 → remains 4.
- Upstream bubble: valid[g] drops for 2 cycles mid-packet → xfer=0 and grant unchanged. A competing req from another input is not granted until after the tail.
- rst asserted while LOCKED with credit_cnt=1 → next cycle grant=0, busy=0, credit_cnt=4, ptr=0.

Source files
------------

// File: rtl/output_port_arbiter_if.sv
// output_port_arbiter_if
// Bundles the handshake between the input-port side of the router (LBDR
// requests, FIFO status, downstream credit returns) and one output-port
// arbiter.
//   req        [4:0]        per-input request for this output (0=N,1=E,2=W,3=S,4=L)
//   valid      [4:0]        per-input FIFO non-empty
//   tail       [4:0]        per-input head flit is a TAIL flit
//   credit_in               downstream FIFO freed one slot
//   grant      [4:0]        one-hot crossbar select, 0 when idle
//   xfer                    flit moves this cycle
//   credit_cnt [CNT_W-1:0]  downstream free-slot count
//   busy                    arbiter locked to a packet
// Modport master drives the requests (router side), slave is the arbiter.
interface output_port_arbiter_if #(
  parameter int CNT_W = 3
);
  logic [4:0]       req;
  logic [4:0]       valid;
  logic [4:0]       tail;
  logic             credit_in;
  logic [4:0]       grant;
  logic             xfer;
  logic [CNT_W-1:0] credit_cnt;
  logic             busy;

  modport master (
    output req, valid, tail, credit_in,
    input  grant, xfer, credit_cnt, busy
  );

  modport slave (
    input  req, valid, tail, credit_in,
    output grant, xfer, credit_cnt, busy
  );
endinterface

// File: rtl/output_port_arbiter.sv
// output_port_arbiter
// Wormhole arbiter for one output of the 5-port mesh router. Locks the
// output to one input from the HEADER flit until its TAIL flit has moved,
// and gates every flit on a credit counter mirroring free slots in the
// downstream input FIFO.
// Ports:
//   clk   clock
//   rst   synchronous, active-high reset
//   arb   output_port_arbiter_if.slave (req/valid/tail/credit_in in,
//         grant/xfer/credit_cnt/busy out)
// Parameters:
//   CREDITS  downstream FIFO depth, reset value of credit_cnt
//   CNT_W    credit counter width, must hold CREDITS
// Configuration macro:
//   OUT_ARB_RR_EN  defined   -> round-robin, pointer moves past the last
//                               input that finished a packet
//                  undefined -> fixed priority, N highest, L lowest
module output_port_arbiter #(
  parameter int CREDITS = 4,
  parameter int CNT_W   = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  output_port_arbiter_if.slave   arb
);

  typedef enum logic {IDLE, LOCKED} state_t;

  localparam logic [CNT_W-1:0] CREDITS_V = CNT_W'(CREDITS);

  state_t           state;
  logic [4:0]       grant;
  logic             busy;
  logic [CNT_W-1:0] credit_cnt;
  logic [2:0]       ptr;

  logic [4:0]       cand;
  logic [2:0]       win_idx;
  logic             win_found;
  int               search_idx;
  logic             xfer;
  logic             grant_tail;

  assign cand = arb.req & arb.valid;

  // The held input may move a flit only if it has one and downstream has room;
  // the registered count is used, so a credit arriving now cannot help this cycle.
  assign xfer       = (state == LOCKED) && (|(grant & arb.valid)) && (credit_cnt != '0);
  assign grant_tail = |(grant & arb.tail);

  // Circular first-set search over the eligible inputs starting at ptr.
  always_comb begin
    win_idx    = 3'd0;
    win_found  = 1'b0;
    search_idx = 0;
    for (int k = 0; k < 5; k++) begin
      search_idx = (int'(ptr) + k) % 5;
      if (!win_found && cand[search_idx]) begin
        win_found = 1'b1;
        win_idx   = 3'(search_idx);
      end
    end
  end

`ifdef OUT_ARB_RR_EN
  logic [2:0] grant_idx;
  logic [2:0] ptr_next;

  // Binary index of the held input, used to advance the pointer past it.
  always_comb begin
    grant_idx = 3'd0;
    for (int i = 0; i < 5; i++) begin
      if (grant[i]) grant_idx = 3'(i);
    end
  end

  assign ptr_next = (grant_idx == 3'd4) ? 3'd0 : grant_idx + 3'd1;

  // Pointer moves only when a packet completes, so the next search starts
  // just after the input that was served last.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 3'd0;
    end else if (xfer && grant_tail) begin
      ptr <= ptr_next;
    end
  end
`else
  // Fixed priority is the circular search pinned to start at N.
  assign ptr = 3'd0;
`endif

  // Credit counter: a flit sent and a credit returned in the same cycle
  // cancel; a credit returned at full is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      credit_cnt <= CREDITS_V;
    end else begin
      case ({xfer, arb.credit_in})
        2'b10:   credit_cnt <= credit_cnt - 1'b1;
        2'b01:   if (credit_cnt != CREDITS_V) credit_cnt <= credit_cnt + 1'b1;
        default: credit_cnt <= credit_cnt;
      endcase
    end
  end

  // Lock/unlock FSM. req is deliberately ignored while LOCKED so a competing
  // input cannot steal the output in the middle of a packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= 5'b00000;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            state <= LOCKED;
            grant <= 5'b00001 << win_idx;
            busy  <= 1'b1;
          end else begin
            grant <= 5'b00000;
            busy  <= 1'b0;
          end
        end
        LOCKED: begin
          if (xfer && grant_tail) begin
            state <= IDLE;
            grant <= 5'b00000;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          grant <= 5'b00000;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign arb.grant      = grant;
  assign arb.busy       = busy;
  assign arb.credit_cnt = credit_cnt;
  assign arb.xfer       = xfer;

endmodule

// File: tb/tb_output_port_arbiter.sv
// tb_output_port_arbiter
// Directed-vector bench for output_port_arbiter. Inputs change just after
// the falling edge and outputs are checked 1 time unit later, so every
// check sees the registered state of the current cycle together with the
// combinational xfer for the applied inputs. Expected values for the
// N/E alternation depend on OUT_ARB_RR_EN.
module tb_output_port_arbiter;

  logic clk;
  logic rst;
  int   checkCount;
  int   passCount;

  output_port_arbiter_if #(.CNT_W(3)) arbBus ();

  output_port_arbiter #(.CREDITS(4), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .arb (arbBus)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Drives all inputs for the current cycle and settles before checking.
  task automatic applyStimulus(input logic [4:0] r, input logic [4:0] v,
                               input logic [4:0] t, input logic c);
    arbBus.req       = r;
    arbBus.valid     = v;
    arbBus.tail      = t;
    arbBus.credit_in = c;
    #1;
  endtask

  // Checks every output of the current cycle against hand-computed values.
  task automatic checkCycle(input string tag, input logic [4:0] g, input logic x,
                            input logic [2:0] cnt, input logic b);
    checkOutput({tag, " grant"}, {3'b000, arbBus.grant}, {3'b000, g});
    checkOutput({tag, " xfer"},  {7'b0, arbBus.xfer},    {7'b0, x});
    checkOutput({tag, " cnt"},   {5'b0, arbBus.credit_cnt}, {5'b0, cnt});
    checkOutput({tag, " busy"},  {7'b0, arbBus.busy},    {7'b0, b});
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  logic [4:0] altExp [4];

  initial begin
    checkCount = 0;
    passCount  = 0;
`ifdef OUT_ARB_RR_EN
    altExp = '{5'b00001, 5'b00010, 5'b00001, 5'b00010};
`else
    altExp = '{5'b00001, 5'b00001, 5'b00001, 5'b00001};
`endif

    // Reset
    rst = 1'b1;
    applyStimulus(5'b0, 5'b0, 5'b0, 1'b0);
    repeat (2) step();
    rst = 1'b0;
    #1;
    checkCycle("reset", 5'b00000, 1'b0, 3'd4, 1'b0);

    // 3-flit packet from L
    applyStimulus(5'b10000, 5'b10000, 5'b00000, 1'b0);
    checkCycle("l idle", 5'b00000, 1'b0, 3'd4, 1'b0);
    step();
    applyStimulus(5'b10000, 5'b10000, 5'b00000, 1'b0);
    checkCycle("l f1", 5'b10000, 1'b1, 3'd4, 1'b1);
    step();
    applyStimulus(5'b10000, 5'b10000, 5'b00000, 1'b0);
    checkCycle("l f2", 5'b10000, 1'b1, 3'd3, 1'b1);
    step();
    applyStimulus(5'b10000, 5'b10000, 5'b10000, 1'b0);
    checkCycle("l tail", 5'b10000, 1'b1, 3'd2, 1'b1);
    step();
    applyStimulus(5'b0, 5'b0, 5'b0, 1'b1);
    checkCycle("l done", 5'b00000, 1'b0, 3'd1, 1'b0);
    step();
    // Return credits up to full, then one extra that must be dropped
    for (int i = 2; i <= 4; i++) begin
      applyStimulus(5'b0, 5'b0, 5'b0, 1'b1);
      checkOutput("refill cnt", {5'b0, arbBus.credit_cnt}, 8'(i));
      step();
    end

    // N and E requesting 1-flit packets continuously; credits returned each cycle
    applyStimulus(5'b00011, 5'b00011, 5'b00011, 1'b1);
    for (int p = 0; p < 4; p++) begin
      checkCycle("alt idle", 5'b00000, 1'b0, 3'd4, 1'b0);
      step();
      checkCycle("alt grant", altExp[p], 1'b1, 3'd4, 1'b1);
      step();
    end

    // Credit exhaustion on a 6-flit packet from S
    applyStimulus(5'b01000, 5'b01000, 5'b00000, 1'b0);
    checkCycle("s idle", 5'b00000, 1'b0, 3'd4, 1'b0);
    step();
    for (int i = 0; i < 4; i++) begin
      checkCycle("s flit", 5'b01000, 1'b1, 3'(4 - i), 1'b1);
      step();
    end
    checkCycle("s stall1", 5'b01000, 1'b0, 3'd0, 1'b1);
    step();
    applyStimulus(5'b01000, 5'b01000, 5'b00000, 1'b1);
    checkCycle("s credit same cyc", 5'b01000, 1'b0, 3'd0, 1'b1);
    step();
    applyStimulus(5'b01000, 5'b01000, 5'b00000, 1'b0);
    checkCycle("s flit5", 5'b01000, 1'b1, 3'd1, 1'b1);
    step();
    applyStimulus(5'b01000, 5'b01000, 5'b01000, 1'b1);
    checkCycle("s stall2", 5'b01000, 1'b0, 3'd0, 1'b1);
    step();
    applyStimulus(5'b01000, 5'b01000, 5'b01000, 1'b0);
    checkCycle("s tail", 5'b01000, 1'b1, 3'd1, 1'b1);
    step();
    applyStimulus(5'b0, 5'b0, 5'b0, 1'b1);
    checkCycle("s done", 5'b00000, 1'b0, 3'd0, 1'b0);
    step();

    // Simultaneous xfer and credit_in at credit_cnt=2
    applyStimulus(5'b0, 5'b0, 5'b0, 1'b1);
    checkOutput("w pre cnt", {5'b0, arbBus.credit_cnt}, 8'd1);
    step();
    applyStimulus(5'b00100, 5'b00100, 5'b00000, 1'b0);
    checkCycle("w idle", 5'b00000, 1'b0, 3'd2, 1'b0);
    step();
    applyStimulus(5'b00100, 5'b00100, 5'b00000, 1'b1);
    checkCycle("w both", 5'b00100, 1'b1, 3'd2, 1'b1);
    step();
    applyStimulus(5'b00100, 5'b00100, 5'b00100, 1'b0);
    checkCycle("w tail", 5'b00100, 1'b1, 3'd2, 1'b1);
    step();
    applyStimulus(5'b0, 5'b0, 5'b0, 1'b0);
    checkCycle("w done", 5'b00000, 1'b0, 3'd1, 1'b0);
    step();

    // Refill to 4
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(5'b0, 5'b0, 5'b0, 1'b1);
      checkOutput("refill2 cnt", {5'b0, arbBus.credit_cnt}, 8'(i));
      step();
    end

    // Upstream bubble on N with L competing
    applyStimulus(5'b00001, 5'b00001, 5'b00000, 1'b0);
    checkCycle("n idle", 5'b00000, 1'b0, 3'd4, 1'b0);
    step();
    applyStimulus(5'b10001, 5'b10001, 5'b00000, 1'b0);
    checkCycle("n f1", 5'b00001, 1'b1, 3'd4, 1'b1);
    step();
    applyStimulus(5'b10001, 5'b10000, 5'b00000, 1'b0);
    checkCycle("n bubble1", 5'b00001, 1'b0, 3'd3, 1'b1);
    step();
    applyStimulus(5'b10001, 5'b10000, 5'b00000, 1'b0);
    checkCycle("n bubble2", 5'b00001, 1'b0, 3'd3, 1'b1);
    step();
    applyStimulus(5'b10001, 5'b10001, 5'b00001, 1'b0);
    checkCycle("n tail", 5'b00001, 1'b1, 3'd3, 1'b1);
    step();
    applyStimulus(5'b10000, 5'b10000, 5'b00000, 1'b0);
    checkCycle("n done", 5'b00000, 1'b0, 3'd2, 1'b0);
    step();
    applyStimulus(5'b10000, 5'b10000, 5'b00000, 1'b0);
    checkCycle("l2 f1", 5'b10000, 1'b1, 3'd2, 1'b1);
    step();

    // Reset while LOCKED with credit_cnt=1
    applyStimulus(5'b10000, 5'b10000, 5'b00000, 1'b0);
    checkCycle("pre rst", 5'b10000, 1'b1, 3'd1, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    applyStimulus(5'b00011, 5'b00011, 5'b00000, 1'b0);
    checkCycle("mid rst", 5'b00000, 1'b0, 3'd4, 1'b0);
    step();
    // Pointer back at 0: N must beat E in either arbitration mode
    applyStimulus(5'b00011, 5'b00011, 5'b00000, 1'b0);
    checkCycle("post rst ptr", 5'b00001, 1'b1, 3'd4, 1'b1);
    step();
    applyStimulus(5'b0, 5'b0, 5'b0, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
